sprite_reg_master: RTL and testbench
====================================

# sprite_reg_master

Avalon-MM write master that drives the sprite-position register file of the VGA sprite peripheral from hardware game logic. At each vertical-blank start it snapshots the game-state positions, then sweeps register addresses 0..NUM_REGS-1 in order. It writes only the registers whose value differs from the last value it delivered, using full waitrequest handshaking. It sits between the game-logic FSM and the VGA peripheral's chipselect/write/address/writedata slave port.

## Interface
- NUM_REGS, 10: number of sprite registers. Register i corresponds to slave address i, in the order dino_x, dino_y, jump_x, jump_y, duck_x, duck_y, s_cac_x, s_cac_y, godzilla_x, godzilla_y.
- DATA_W, 8: width of each register value.
- ADDR_W, 9: slave address width.

- clk  in  1  system clock (50 MHz domain of the VGA peripheral).
- reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- reg_values  in  NUM_REGS*DATA_W  packed values; register i occupies [i*DATA_W +: DATA_W].
- force_all  in  1  request that the next sweep write every register.
- waitrequest  in  1  slave stall; a transfer completes at a rising edge where write=1 and waitrequest=0.
- chipselect  out  1  always equal to write.
- write  out  1  write strobe.
- address  out  ADDR_W  register index, zero-extended.
- writedata  out  32  value zero-extended; bits 31:DATA_W are always 0.
- busy  out  1  high whenever state is not IDLE.
- sweep_done  out  1  one-cycle pulse at end of each sweep.
- overrun_count  out  8  count of frame_start pulses ignored while busy; saturates at 255.

## Operation
- Storage:
  - snapshot[NUM_REGS]: values captured at sweep start.
  - last_written[NUM_REGS]: values most recently accepted by the slave.
  - idx: register index.
  - force_pending: sticky flag set by force_all.
  - sweep_force: force flag for the current sweep.
- States are IDLE, SCAN, WRITE, DONE.
- IDLE:
  - On frame_start, capture reg_values into snapshot.
  - Set sweep_force <= force_pending | force_all and clear force_pending. A force_all in this same cycle is consumed by this sweep.
  - Set idx <= 0 and go to SCAN.
- SCAN (one cycle per index):
  - If sweep_force, or snapshot[idx] != last_written[idx], go to WRITE.
  - Otherwise, if idx == NUM_REGS-1, go to DONE; else idx++.
- WRITE:
  - Drive write=chipselect=1, address=idx, writedata=snapshot[idx].
  - Hold all of these stable while waitrequest=1.
  - On an edge with waitrequest=0: set last_written[idx] <= snapshot[idx]. Then, if idx == NUM_REGS-1, go to DONE; else idx++ and go to SCAN.
- DONE: assert sweep_done for one cycle, then go to IDLE.
- force_all when not in an IDLE capture cycle: sets force_pending, which applies to the next sweep.
- frame_start when state != IDLE (this includes DONE): the pulse is ignored and overrun_count increments, saturating at 255.
- reg_values changes during a sweep have no effect on that sweep.
- Reset:
  - State goes to IDLE and idx to 0.
  - write, chipselect, address, writedata, busy, sweep_done all go to 0.
  - overrun_count goes to 0 and last_written entries go to 0.
  - force_pending goes to 1, so the first sweep after reset writes all registers.
- Reset mid-WRITE: write drops in the cycle after the reset edge. The slave may hold a partial sweep; this is repaired by the forced full sweep that follows reset.

## Timing
- Outputs are registered.
- If frame_start is sampled at edge E0, busy=1 from E0 onward.
- A dirty register costs 2 cycles (SCAN + WRITE) plus any wait cycles. A clean register costs 1 cycle.
- All registers dirty, waitrequest=0:
  - write is high in the cycles after E1, E3, …, E19.
  - Transfers complete at E2, E4, …, E20.
  - sweep_done is high in the cycle after E20; busy=0 after E21.
- No registers dirty: sweep_done is high after E10; busy=0 after E11.
- Back-to-back writes are never issued; write=0 for at least one cycle between transfers.
- Worst-case sweep with no waits is 2*NUM_REGS+2 cycles, well inside vertical blank.

## Test plan
- After reset, pulse frame_start with values 100,100,200,150,44,200,244,100,100,4 and waitrequest=0 -> 10 writes to addresses 0..9 carrying exactly these data, sweep_done 21 cycles after frame_start, overrun_count=0.
- Repeat the sweep with only dino_x changed 100→104 -> exactly one write, address 0 with writedata 104; sweep_done 12 cycles after frame_start.
- Repeat with unchanged values -> zero writes, sweep_done 11 cycles after frame_start. Then pulse force_all mid-idle and frame_start -> all 10 addresses written.
- Hold waitrequest high for 3 cycles on the address-3 write -> write, address=3 and writedata stay stable 4 cycles, then the sweep continues; total sweep 3 cycles longer.
- Pulse frame_start twice during a sweep -> overrun_count=2 and the sweep is not restarted. Pulse 300 times while busy -> overrun_count holds at 255.
- Assert reset during the address-5 write -> write=0 the next cycle. The following frame_start with unchanged values -> all 10 registers written.

Source files
------------

// File: rtl/sprite_reg_master.sv
// Avalon-MM write master for the VGA sprite-position register file.
// Snapshots game-state positions at frame start and writes only the registers that changed.
module sprite_reg_master #(
  parameter int NUM_REGS = 10,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  input  logic [NUM_REGS*DATA_W-1:0]   reg_values,
  input  logic                         force_all,
  input  logic                         waitrequest,
  output logic                         chipselect,
  output logic                         write,
  output logic [ADDR_W-1:0]            address,
  output logic [31:0]                  writedata,
  output logic                         busy,
  output logic                         sweep_done,
  output logic [7:0]                   overrun_count
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

  state_t                           state;
  logic [IDX_W-1:0]                 idx;
  logic [NUM_REGS-1:0][DATA_W-1:0]  snapshot;
  logic [NUM_REGS-1:0][DATA_W-1:0]  last_written;
  logic [NUM_REGS-1:0]              dirty;
  logic                             force_pending;
  logic                             sweep_force;
  logic                             capture;

  // Per-register change detect against what the slave last accepted.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dirty
    assign dirty[i] = snapshot[i] != last_written[i];
  end

  assign capture = (state == IDLE) && frame_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      snapshot      <= '0;
      last_written  <= '0;
      force_pending <= 1'b1;
      sweep_force   <= 1'b0;
      write         <= 1'b0;
      chipselect    <= 1'b0;
      address       <= '0;
      writedata     <= '0;
      busy          <= 1'b0;
      sweep_done    <= 1'b0;
      overrun_count <= '0;
    end else begin
      sweep_done <= 1'b0;

      if (frame_start && state != IDLE && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;

      // A force request outside the capture cycle carries over to the next sweep.
      if (force_all && !capture)
        force_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            snapshot      <= reg_values;
            sweep_force   <= force_pending | force_all;
            force_pending <= 1'b0;
            idx           <= '0;
            busy          <= 1'b1;
            state         <= SCAN;
          end
        end
        SCAN: begin
          if (sweep_force || dirty[idx]) begin
            write      <= 1'b1;
            chipselect <= 1'b1;
            address    <= ADDR_W'(idx);
            writedata  <= 32'(snapshot[idx]);
            state      <= WRITE;
          end else if (idx == LAST_IDX) begin
            sweep_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        WRITE: begin
          if (!waitrequest) begin
            last_written[idx] <= snapshot[idx];
            write             <= 1'b0;
            chipselect        <= 1'b0;
            if (idx == LAST_IDX) begin
              sweep_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_reg_master.sv
// Directed bench for sprite_reg_master: sweep latency, dirty filtering, stalls, overrun, reset.
module tb_sprite_reg_master;

  logic        clk = 1'b0;
  logic        reset, frame_start, force_all, waitrequest;
  logic [79:0] reg_values;
  logic        chipselect, write, busy, sweep_done;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [7:0]  overrun_count;

  int pass_cnt = 0;
  int total    = 0;

  logic [8:0]  tx_addr[$];
  logic [31:0] tx_data[$];
  int          b2b_err = 0;
  int          cs_err  = 0;
  logic        prev_xfer = 1'b0;

  sprite_reg_master dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .reg_values(reg_values),
    .force_all(force_all), .waitrequest(waitrequest), .chipselect(chipselect),
    .write(write), .address(address), .writedata(writedata), .busy(busy),
    .sweep_done(sweep_done), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge, so negedge values are what the next edge samples.
  always @(negedge clk) begin
    if (chipselect !== write) cs_err <= cs_err + 1;
    if (!reset) begin
      if (prev_xfer && write) b2b_err <= b2b_err + 1;
      if (write && !waitrequest) begin
        tx_addr.push_back(address);
        tx_data.push_back(writedata);
      end
      prev_xfer <= write && !waitrequest;
    end else begin
      prev_xfer <= 1'b0;
    end
  end

  function automatic logic [79:0] pack(input int a[10]);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = a[i][7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Starts a sweep (frame_start seen at E0) and returns edges from E0 until sweep_done is seen.
  task automatic do_sweep(input logic [79:0] vals, input logic frc, input int stall_addr,
                          input int n_pulses, output int lat, output int hold);
    int   stall_left;
    bit   stalled;
    logic [7:0] exp_d;
    stall_left = 0;
    stalled    = 0;
    exp_d      = (stall_addr >= 0) ? vals[stall_addr*8 +: 8] : 8'd0;
    tx_addr.delete();
    tx_data.delete();
    reg_values = vals; force_all = frc; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; force_all = 1'b0; reg_values = ~vals;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_at_start: got %b expected 1", busy); else pass_cnt++;
    lat  = 0;
    hold = 0;
    while (lat < 200) begin
      frame_start = (lat == 3 && n_pulses >= 1) || (lat == 6 && n_pulses >= 2);
      if (write && address == stall_addr) begin
        if (writedata == 32'(exp_d)) hold++;
        if (!stalled) begin stalled = 1; stall_left = 3; end
      end
      waitrequest = stall_left > 0;
      if (stall_left > 0) stall_left--;
      tick();
      lat++;
      if (sweep_done) break;
    end
    frame_start = 1'b0; waitrequest = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL busy_after_done: got %b expected 0", busy); else pass_cnt++;
  endtask

  int base[10] = '{100, 100, 200, 150, 44, 200, 244, 100, 100, 4};
  logic [79:0] v1, v2, v3;

  task automatic test_reset();
    reset = 1'b1; frame_start = 1'b0; force_all = 1'b0; waitrequest = 1'b0; reg_values = '0;
    tick(); tick();
    total++;
    if ({write, chipselect, busy, sweep_done} !== 4'b0)
      $display("FAIL reset_ctrl: got %b expected 0000", {write, chipselect, busy, sweep_done});
    else pass_cnt++;
    total++;
    if (address !== 9'd0 || writedata !== 32'd0)
      $display("FAIL reset_bus: got addr %0d data %0d expected 0 0", address, writedata);
    else pass_cnt++;
    total++;
    if (overrun_count !== 8'd0) $display("FAIL reset_overrun: got %0d expected 0", overrun_count);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_sweep();
    int lat, hold;
    do_sweep(v1, 1'b0, -1, 0, lat, hold);
    total++;
    if (lat !== 20) $display("FAIL full_latency: got %0d expected 20", lat); else pass_cnt++;
    total++;
    if (tx_addr.size() !== 10) $display("FAIL full_count: got %0d expected 10", tx_addr.size());
    else pass_cnt++;
    for (int i = 0; i < tx_addr.size() && i < 10; i++) begin
      total++;
      if (tx_addr[i] !== 9'(i) || tx_data[i] !== 32'(base[i]))
        $display("FAIL full_tx%0d: got addr %0d data %0d expected %0d %0d",
                 i, tx_addr[i], tx_data[i], i, base[i]);
      else pass_cnt++;
    end
    total++;
    if (overrun_count !== 8'd0) $display("FAIL full_overrun: got %0d expected 0", overrun_count);
    else pass_cnt++;
  endtask

  task automatic test_one_dirty();
    int lat, hold;
    do_sweep(v2, 1'b0, -1, 0, lat, hold);
    total++;
    if (lat !== 11) $display("FAIL dirty_latency: got %0d expected 11", lat); else pass_cnt++;
    total++;
    if (tx_addr.size() !== 1) $display("FAIL dirty_count: got %0d expected 1", tx_addr.size());
    else pass_cnt++;
    if (tx_addr.size() > 0) begin
      total++;
      if (tx_addr[0] !== 9'd0 || tx_data[0] !== 32'd104)
        $display("FAIL dirty_tx: got addr %0d data %0d expected 0 104", tx_addr[0], tx_data[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_then_force();
    int lat, hold;
    do_sweep(v2, 1'b0, -1, 0, lat, hold);
    total++;
    if (lat !== 10) $display("FAIL clean_latency: got %0d expected 10", lat); else pass_cnt++;
    total++;
    if (tx_addr.size() !== 0) $display("FAIL clean_count: got %0d expected 0", tx_addr.size());
    else pass_cnt++;
    force_all = 1'b1; tick(); force_all = 1'b0; tick();
    do_sweep(v2, 1'b0, -1, 0, lat, hold);
    total++;
    if (lat !== 20) $display("FAIL force_latency: got %0d expected 20", lat); else pass_cnt++;
    total++;
    if (tx_addr.size() !== 10) $display("FAIL force_count: got %0d expected 10", tx_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_waitrequest();
    int lat, hold;
    do_sweep(v3, 1'b1, 3, 0, lat, hold);
    total++;
    if (lat !== 23) $display("FAIL stall_latency: got %0d expected 23", lat); else pass_cnt++;
    total++;
    if (hold !== 4) $display("FAIL stall_hold: got %0d expected 4", hold); else pass_cnt++;
    total++;
    if (tx_addr.size() !== 10) $display("FAIL stall_count: got %0d expected 10", tx_addr.size());
    else pass_cnt++;
    if (tx_addr.size() > 3) begin
      total++;
      if (tx_addr[3] !== 9'd3 || tx_data[3] !== 32'd151)
        $display("FAIL stall_tx3: got addr %0d data %0d expected 3 151", tx_addr[3], tx_data[3]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overrun();
    int lat, hold, n;
    do_sweep(v3, 1'b0, -1, 2, lat, hold);
    total++;
    if (overrun_count !== 8'd2) $display("FAIL overrun_two: got %0d expected 2", overrun_count);
    else pass_cnt++;
    total++;
    if (lat !== 10) $display("FAIL overrun_latency: got %0d expected 10", lat); else pass_cnt++;
    tx_addr.delete(); tx_data.delete();
    waitrequest = 1'b1; reg_values = v3; force_all = 1'b1; frame_start = 1'b1;
    tick();
    force_all = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    frame_start = 1'b0;
    tick();
    total++;
    if (overrun_count !== 8'd255) $display("FAIL overrun_sat: got %0d expected 255", overrun_count);
    else pass_cnt++;
    total++;
    if (write !== 1'b1 || address !== 9'd0)
      $display("FAIL overrun_stalled: got write %b addr %0d expected 1 0", write, address);
    else pass_cnt++;
    waitrequest = 1'b0;
    n = 0;
    while (!sweep_done && n < 100) begin tick(); n++; end
    total++;
    if (!sweep_done) $display("FAIL overrun_timeout: got no sweep_done expected pulse");
    else pass_cnt++;
    tick(); tick();
  endtask

  task automatic test_reset_mid_write();
    int lat, hold, n;
    reg_values = v3; force_all = 1'b1; frame_start = 1'b1;
    tick();
    force_all = 1'b0; frame_start = 1'b0;
    n = 0;
    while (!(write && address == 9'd5) && n < 50) begin tick(); n++; end
    total++;
    if (!(write && address == 9'd5))
      $display("FAIL rst_find_a5: got write %b addr %0d expected 1 5", write, address);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (write !== 1'b0 || chipselect !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_write_drop: got %b%b%b expected 000", write, chipselect, busy);
    else pass_cnt++;
    total++;
    if (overrun_count !== 8'd0) $display("FAIL rst_overrun: got %0d expected 0", overrun_count);
    else pass_cnt++;
    tick();
    do_sweep(v3, 1'b0, -1, 0, lat, hold);
    total++;
    if (tx_addr.size() !== 10) $display("FAIL rst_full_count: got %0d expected 10", tx_addr.size());
    else pass_cnt++;
    total++;
    if (lat !== 20) $display("FAIL rst_full_latency: got %0d expected 20", lat); else pass_cnt++;
  endtask

  task automatic test_protocol();
    total++;
    if (b2b_err !== 0) $display("FAIL back_to_back: got %0d expected 0", b2b_err); else pass_cnt++;
    total++;
    if (cs_err !== 0) $display("FAIL cs_eq_write: got %0d expected 0", cs_err); else pass_cnt++;
  endtask

  initial begin
    int t[10];
    v1 = pack(base);
    t = base; t[0] = 104; v2 = pack(t);
    t[3] = 151; v3 = pack(t);
    test_reset();
    test_full_sweep();
    test_one_dirty();
    test_clean_then_force();
    test_waitrequest();
    test_overrun();
    test_reset_mid_write();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
